// File: rtl/unsigned_mul_8x8_ha_array_accum.sv
// Final-addition pipeline for the approximate 8x8 multipliers: weights the four
// half-adder rows, sums them over two registered stages, saturates to 16 bits.
module unsigned_mul_8x8_ha_array_accum #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [6:0]       ha_array_1_b,
  input  logic [6:0]       ha_array_2_b,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [8:0]       ha_array_1_t,
  input  logic [8:0]       ha_array_2_t,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      p,
  output logic             sat,
  output logic [CNT_W-1:0] res_cnt,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             clr_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Carry bits sit two positions above the sum bits of the same row.
  function automatic logic [9:0] row_value(input logic [8:0] t, input logic [6:0] b);
    return {1'b0, t} + {1'b0, b, 2'b00};
  endfunction

  // Adjacent rows differ by a factor of 4 (two multiplier bits per row).
  function automatic logic [12:0] pair_sum(input logic [9:0] lo, input logic [9:0] hi);
    return {3'b000, lo} + {1'b0, hi, 2'b00};
  endfunction

  function automatic logic [16:0] final_sum(input logic [12:0] lo, input logic [12:0] hi);
    return {4'b0000, lo} + {hi, 4'b0000};
  endfunction

  // Returns {sat, p}; anything beyond 16 bits clips to all-ones.
  function automatic logic [16:0] saturate16(input logic [16:0] s);
    if (s[16]) return {1'b1, 16'hFFFF};
    else       return {1'b0, s[15:0]};
  endfunction

  logic             r_vld_p1;
  logic             r_vld_p2;
  logic [12:0]      r_s01_p1;
  logic [12:0]      r_s23_p1;
  logic [15:0]      r_p_p2;
  logic             r_sat_p2;
  logic [CNT_W-1:0] r_res_cnt;
  logic [CNT_W-1:0] r_sat_cnt;

  logic             w_ld_p2;
  logic             w_ld_p1;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [9:0]       w_r0;
  logic [9:0]       w_r1;
  logic [9:0]       w_r2;
  logic [9:0]       w_r3;
  logic [16:0]      w_sum;
  logic [16:0]      w_sat_p;

  // A stage may load when empty or when its occupant moves on this cycle.
  assign w_ld_p2    = !r_vld_p2 || out_ready;
  assign w_ld_p1    = !r_vld_p1 || w_ld_p2;
  assign in_ready   = w_ld_p1;
  assign w_in_xfer  = in_valid && w_ld_p1;
  assign w_out_xfer = r_vld_p2 && out_ready;

  assign w_r0 = row_value(ha_array_0_t, ha_array_0_b);
  assign w_r1 = row_value(ha_array_1_t, ha_array_1_b);
  assign w_r2 = row_value(ha_array_2_t, ha_array_2_b);
  assign w_r3 = row_value(ha_array_3_t, ha_array_3_b);

  // ---- stage 1: row pairs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (w_ld_p1) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_s01_p1 <= pair_sum(w_r0, w_r1);
      r_s23_p1 <= pair_sum(w_r2, w_r3);
    end
  end

  assign w_sum   = final_sum(r_s01_p1, r_s23_p1);
  assign w_sat_p = saturate16(w_sum);

  // ---- stage 2: final sum and saturation ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_p_p2   <= 16'h0000;
      r_sat_p2 <= 1'b0;
    end else if (w_ld_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_p_p2   <= w_sat_p[15:0];
        r_sat_p2 <= w_sat_p[16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_cnt <= '0;
      r_sat_cnt <= '0;
    end else if (clr_cnt) begin
      r_res_cnt <= '0;
      r_sat_cnt <= '0;
    end else if (w_out_xfer) begin
      r_res_cnt <= r_res_cnt + CNT_ONE;
      if (r_sat_p2) r_sat_cnt <= r_sat_cnt + CNT_ONE;
    end
  end

  assign out_valid = r_vld_p2;
  assign p         = r_p_p2;
  assign sat       = r_sat_p2;
  assign res_cnt   = r_res_cnt;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_accum.sv
// Directed and model-checked bench for the half-adder-array final-addition pipeline.
module tb_unsigned_mul_8x8_ha_array_accum;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       bv [0:3];
  logic [8:0]       tv [0:3];
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      p;
  logic             sat;
  logic [CNT_W-1:0] res_cnt;
  logic [CNT_W-1:0] sat_cnt;
  logic             clr_cnt;

  int n_checks;
  int n_fail;
  int exp_res;
  int exp_sat;

  unsigned_mul_8x8_ha_array_accum #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(bv[0]), .ha_array_1_b(bv[1]), .ha_array_2_b(bv[2]), .ha_array_3_b(bv[3]),
    .ha_array_0_t(tv[0]), .ha_array_1_t(tv[1]), .ha_array_2_t(tv[2]), .ha_array_3_t(tv[3]),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .sat(sat),
    .res_cnt(res_cnt), .sat_cnt(sat_cnt), .clr_cnt(clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rows(input logic [8:0] t0, input logic [8:0] t1, input logic [8:0] t2,
                           input logic [8:0] t3, input logic [6:0] b0, input logic [6:0] b1,
                           input logic [6:0] b2, input logic [6:0] b3);
    tv[0] = t0; tv[1] = t1; tv[2] = t2; tv[3] = t3;
    bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
  endtask

  // Bit-by-bit weighted sum, saturated; returns {sat, p}.
  function automatic logic [16:0] model();
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) if (tv[k][i]) s += (1 << (2*k + i));
      for (int j = 0; j < 7; j++) if (bv[k][j]) s += (1 << (2*k + j + 2));
    end
    if (s >= 65536) return {1'b1, 16'hFFFF};
    return {1'b0, s[15:0]};
  endfunction

  // Single transaction through an empty pipe with out_ready held high.
  task automatic send_one(input string tag, input logic [15:0] ep, input logic es);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, "_vld_lat1"}, out_valid, 0);
    step();
    check({tag, "_vld_lat2"}, out_valid, 1);
    check({tag, "_p"}, p, ep);
    check({tag, "_sat"}, sat, es);
    step();
    exp_res++;
    if (es) exp_sat++;
    check({tag, "_res_cnt"}, res_cnt, exp_res);
    check({tag, "_sat_cnt"}, sat_cnt, exp_sat);
    check({tag, "_drained"}, out_valid, 0);
  endtask

  logic [16:0] q_exp [$];
  logic [16:0] m;
  logic [16:0] head;
  bit          acc;
  bit          oxf;

  initial begin
    n_checks = 0; n_fail = 0; exp_res = 0; exp_sat = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    load_rows(9'h0, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_p", p, 0);
    check("rst_sat", sat, 0);
    check("rst_res_cnt", res_cnt, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    step();
    check("rst_in_ready_hold", in_ready, 1);
    rst_n = 1'b1;
    step();

    load_rows(9'h0, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    send_one("zero", 16'd0, 1'b0);
    load_rows(9'h1FF, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    send_one("t0max", 16'd511, 1'b0);
    load_rows(9'h0, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h7F);
    send_one("b3max", 16'd32512, 1'b0);
    load_rows(9'h0, 9'h0, 9'h100, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    send_one("t2msb", 16'd4096, 1'b0);
    load_rows(9'h003, 9'h001, 9'h0, 9'h001, 7'h0, 7'h01, 7'h0, 7'h0);
    send_one("mixed", 16'd87, 1'b0);
    load_rows(9'h003, 9'h003, 9'h013, 9'h1FF, 7'h0, 7'h0, 7'h0, 7'h7F);
    send_one("edge65535", 16'hFFFF, 1'b0);
    load_rows(9'h004, 9'h003, 9'h013, 9'h1FF, 7'h0, 7'h0, 7'h0, 7'h7F);
    send_one("edge65536", 16'hFFFF, 1'b1);
    load_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    send_one("allmax", 16'hFFFF, 1'b1);

    // Back-to-back with the consumer stalled for five cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    load_rows(9'h1FF, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    #1;
    check("bb_rdy_a", in_ready, 1);
    step();
    load_rows(9'h0, 9'h0, 9'h100, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    check("bb_rdy_b", in_ready, 1);
    step();
    load_rows(9'h003, 9'h001, 9'h0, 9'h001, 7'h0, 7'h01, 7'h0, 7'h0);
    for (int c = 0; c < 3; c++) begin
      check("bb_stall_rdy", in_ready, 0);
      check("bb_stall_p", p, 16'd511);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bb_release_rdy", in_ready, 1);
    check("bb_out_a", p, 16'd511);
    step();
    in_valid = 1'b0;
    check("bb_out_b_vld", out_valid, 1);
    check("bb_out_b", p, 16'd4096);
    step();
    check("bb_out_c_vld", out_valid, 1);
    check("bb_out_c", p, 16'd87);
    step();
    check("bb_empty", out_valid, 0);
    exp_res += 3;
    check("bb_res_cnt", res_cnt, exp_res);

    // Randomised traffic against the bit-weight model.
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        tv[k] = 9'($urandom_range(0, 511));
        bv[k] = 7'($urandom_range(0, 127));
      end
      #1;
      acc = in_valid && in_ready;
      oxf = out_valid && out_ready;
      m   = model();
      if (oxf) begin
        if (q_exp.size() == 0) check("rnd_unexpected_out", 1, 0);
        else begin
          head = q_exp.pop_front();
          check("rnd_result", {sat, p}, head);
          exp_res++;
          if (head[16]) exp_sat++;
        end
      end
      if (acc) q_exp.push_back(m);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        if (q_exp.size() == 0) check("drain_unexpected_out", 1, 0);
        else begin
          head = q_exp.pop_front();
          check("drain_result", {sat, p}, head);
          exp_res++;
          if (head[16]) exp_sat++;
        end
      end
      step();
    end
    check("drain_empty", q_exp.size(), 0);
    check("rnd_res_cnt", res_cnt, exp_res[CNT_W-1:0]);
    check("rnd_sat_cnt", sat_cnt, exp_sat[CNT_W-1:0]);

    // Reset with two results in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    load_rows(9'h1FF, 9'h0, 9'h0, 9'h0, 7'h0, 7'h0, 7'h0, 7'h0);
    step();
    step();
    in_valid = 1'b0;
    check("pre_rst_vld", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_res", res_cnt, 0);
    check("mid_rst_sat", sat_cnt, 0);
    check("mid_rst_rdy", in_ready, 1);
    step();
    rst_n = 1'b1;
    exp_res = 0;
    exp_sat = 0;
    step();
    check("post_rst_empty", out_valid, 0);
    load_rows(9'h003, 9'h001, 9'h0, 9'h001, 7'h0, 7'h01, 7'h0, 7'h0);
    send_one("post_rst", 16'd87, 1'b0);

    // Clear coinciding with a saturating output transfer.
    load_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("clr_vld", out_valid, 1);
    check("clr_sat", sat, 1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_res_cnt", res_cnt, 0);
    check("clr_sat_cnt", sat_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unsigned_mul_8x8_ha_array_accum.md
# unsigned_mul_8x8_ha_array_accum

Pipelined final-addition stage for the approximate 8x8 unsigned multipliers. It consumes the four `ha_array` rows (a 7-bit `b` vector and a 9-bit `t` vector per row) produced by the partial-product/half-adder front end. It reconstructs each row's weighted value, sums all four rows into the product, saturates the result to 16 bits and delivers it over a valid/ready handshake. It also maintains result and saturation counters for error-characterisation runs.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` input 1: rising-edge clock; the only clock in the block.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the four rows on the input are valid.
- `in_ready` output 1: the block accepts the rows this cycle.
- `ha_array_0_b`, `ha_array_1_b`, `ha_array_2_b`, `ha_array_3_b` input 7 each: carry vector of row k.
- `ha_array_0_t`, `ha_array_1_t`, `ha_array_2_t`, `ha_array_3_t` input 9 each: sum vector of row k.
- `out_valid` output 1: `p` and `sat` hold a result.
- `out_ready` input 1: the consumer takes the result this cycle.
- `p` output 16: product, saturated.
- `sat` output 1: this result was clipped to 16'hFFFF.
- `res_cnt` output CNT_W: number of results delivered.
- `sat_cnt` output CNT_W: number of delivered results with `sat`=1.
- `clr_cnt` input 1: synchronous clear of both counters.

## Operation
Bit weights and row values:
- Row k (k=0..3) corresponds to multiplier bits x[2k+1:2k].
- Bit `t[i]` has weight 2^(2k+i).
- Bit `b[j]` has weight 2^(2k+j+2).
- Row value `r_k = t_k + (b_k << 2)` is 10 bits unsigned, max 1019. No bit is dropped.

Stage 1 (registered):
- `s01 = r0 + (r1 << 2)`, 13 bits.
- `s23 = r2 + (r3 << 2)`, 13 bits.

Stage 2 (registered):
- `sum = s01 + (s23 << 4)`, 17 bits, max 86615.
- If `sum >= 65536`: `p = 16'hFFFF` and `sat = 1`.
- Otherwise: `p = sum[15:0]` and `sat = 0`.

Handshake rules:
- Input transfer happens when `in_valid && in_ready`.
- Output transfer happens when `out_valid && out_ready`.
- Each stage has its own valid flag. A stage loads when it is empty or when its contents advance in the same cycle.
- `in_ready = !s1_valid || (!s2_valid || out_ready)`. It is combinational from `out_ready` and contains no combinational path from `in_valid`.
- `p` and `sat` stay stable while `out_valid && !out_ready`.
- Data is never lost or duplicated.

Counters:
- `res_cnt` increments on every output transfer.
- `sat_cnt` increments on an output transfer with `sat`=1.
- Both counters wrap modulo 2^CNT_W.
- `clr_cnt` takes priority over an increment in the same cycle; the counter result is 0.

## Timing
- Reset values: `out_valid`=0, `p`=0, `sat`=0, `res_cnt`=0, `sat_cnt`=0, both internal valid flags 0.
- `in_ready` is 1 during and after reset.
- Asserting `rst_n` low mid-operation discards all in-flight results immediately.
- Latency: a row set accepted at edge N appears with `out_valid`=1 after edge N+2 (two registers).
- Throughput: one result per cycle while `out_ready`=1.
- Capacity: 2 entries in flight.
- Stall: if `out_ready`=0 and both stages are full, `in_ready`=0 in that cycle.
- Simultaneous transfers: an output transfer and an input transfer in the same cycle with a full pipe shifts everything forward; `in_ready` stays 1.
- Counter values update on the edge of the transfer and are visible in the following cycle.

## Test plan
- All rows zero, `out_ready`=1 -> `p`=0, `sat`=0, `out_valid` two cycles after acceptance; `res_cnt`=1.
- Only `ha_array_0_t`=9'h1FF -> `p`=511. Only `ha_array_3_b`=7'h7F -> `p`=32512. Only `ha_array_2_t`=9'h100 -> `p`=4096.
- All `t`=9'h1FF and all `b`=7'h7F (sum 86615) -> `p`=16'hFFFF, `sat`=1, `sat_cnt`=1.
- Back-to-back: 3 row sets on consecutive cycles with `out_ready` held 0 for 5 cycles:
  - `in_ready` drops after 2 acceptances and the third set waits.
  - On release, three results emerge in order with no loss; `res_cnt`=3.
- Random row sets against a reference model (weights as above, saturate at 65535) with random `out_ready` -> exact match on every transfer.
- Reset and clear:
  - `rst_n` pulsed low with 2 results in flight -> `out_valid`=0 immediately, counters 0, next accepted set produces a correct result.
  - `clr_cnt` asserted together with a saturating output transfer -> both counters read 0.
